// File: rtl/dram_arb_pkg.sv
// Shared definitions for the DRAM port arbiter: state encoding and
// one-hot helpers usable by any round-robin arbiter up to 8 requesters.
package dram_arb_pkg;

  localparam logic [0:0] ARB    = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  localparam int MAX_REQ = 8;

  // First set bit of valid at or above ptr, wrapping within n requesters.
  function automatic logic [7:0] rr_onehot(input logic [7:0] valid,
                                           input logic [2:0] ptr,
                                           input int n);
    logic [7:0] pick;
    logic found;
    int idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % n;
      if (!found && i < n && valid[idx[2:0]]) begin
        pick[idx[2:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dram_port_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate the request mask by the pointer,
// isolate the lowest set bit, then rotate the one-hot result back.
module rr_pick
  import dram_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [N-1:0] rotated;
  logic [N-1:0] rot_grant;

  always_comb begin
    rotated   = N'({valid, valid} >> ptr);
    rot_grant = rotated & (~rotated + N'(1));
    grant     = N'(({rot_grant, rot_grant} << ptr) >> N);
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one RAM port between NUM_REQ requesters with round-robin grants,
// an optional bounded burst lock and one-hot tagged read responses.
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ-1:0]          req_we_i,
  input  logic [NUM_REQ-1:0]          req_lock_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_rdata_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic                        mem_wr_en_o,
  output logic [DATA_W-1:0]           mem_wr_data_o,
  output logic                        mem_rd_en_o,
  input  logic [DATA_W-1:0]           mem_rd_data_i
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);

  logic [0:0]         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [NUM_REQ-1:0] rsp_valid_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_grant;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (IDX_W)
  ) u_rr_pick (
    .valid (req_valid_i),
    .ptr   (rr_ptr),
    .grant (pick_grant)
  );

  // While locked only the owner may be granted; reset blocks every grant.
  always_comb begin
    owner_mask        = '0;
    owner_mask[owner] = 1'b1;
    if (!rstn_i)
      grant = '0;
    else if (state == LOCKED)
      grant = owner_mask & req_valid_i;
    else
      grant = pick_grant;
    any_grant = |grant;
    grant_idx = IDX_W'(onehot_to_idx(8'(grant)));

    mem_addr_o    = '0;
    mem_wr_en_o   = 1'b0;
    mem_rd_en_o   = 1'b0;
    mem_wr_data_o = '0;
    if (any_grant) begin
      mem_addr_o    = req_addr_i[grant_idx*ADDR_W +: ADDR_W];
      mem_wr_data_o = req_wdata_i[grant_idx*DATA_W +: DATA_W];
      mem_wr_en_o   = req_we_i[grant_idx];
      mem_rd_en_o   = ~req_we_i[grant_idx];
    end
  end

  // A pending response is dropped as soon as reset is seen, not one edge later.
  assign req_ready_o = grant;
  assign rsp_valid_o = rsp_valid_q & {NUM_REQ{rstn_i}};
  assign rsp_rdata_o = (|rsp_valid_o) ? mem_rd_data_i : '0;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state       <= ARB;
      rr_ptr      <= '0;
      owner       <= '0;
      beat_cnt    <= '0;
      rsp_valid_q <= '0;
    end else begin
      rsp_valid_q <= grant & ~req_we_i;
      if (state == ARB) begin
        if (any_grant) begin
          rr_ptr <= next_idx(grant_idx);
          if (req_lock_i[grant_idx] && MAX_BURST > 1) begin
            owner    <= grant_idx;
            beat_cnt <= BEAT_W'(1);
            state    <= LOCKED;
          end
        end
      // Lock ends on a dropped valid, a released lock or the last allowed beat.
      end else if (!req_valid_i[owner] || !req_lock_i[owner] ||
                   beat_cnt >= BEAT_LAST) begin
        state    <= ARB;
        rr_ptr   <= next_idx(owner);
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter with a behavioural one-cycle-latency RAM.
module tb_dram_port_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 16;
  localparam int MAX_BURST = 4;

  logic                      clk_i = 1'b0;
  logic                      rstn_i;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_we_i;
  logic [NUM_REQ-1:0]        req_lock_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]         rsp_rdata_o;
  logic [ADDR_W-1:0]         mem_addr_o;
  logic                      mem_wr_en_o;
  logic [DATA_W-1:0]         mem_wr_data_o;
  logic                      mem_rd_en_o;
  logic [DATA_W-1:0]         mem_rd_data_i;

  logic [DATA_W-1:0] ram [32];

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  dram_port_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .req_valid_i   (req_valid_i),
    .req_we_i      (req_we_i),
    .req_lock_i    (req_lock_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .req_ready_o   (req_ready_o),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wr_en_o   (mem_wr_en_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_rd_en_o   (mem_rd_en_o),
    .mem_rd_data_i (mem_rd_data_i)
  );

  // RAM model: preloaded with 16'h1111*addr, read data one cycle after enable.
  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 16'(16'h1111 * i);
    mem_rd_data_i = '0;
  end

  always @(posedge clk_i) begin
    if (mem_wr_en_o) ram[mem_addr_o] <= mem_wr_data_o;
    if (mem_rd_en_o) mem_rd_data_i <= ram[mem_addr_o];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] we, input logic [3:0] lock);
    req_valid_i = valid;
    req_we_i    = we;
    req_lock_i  = lock;
  endtask

  task automatic setReq(input int k, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    req_addr_i[k*ADDR_W +: ADDR_W]  = addr;
    req_wdata_i[k*DATA_W +: DATA_W] = wdata;
  endtask

  // Inputs change right after a falling edge; outputs are sampled 2ns later.
  task automatic settle();
    #2;
  endtask

  task automatic nextCycle();
    @(negedge clk_i);
  endtask

  initial begin
    int p;
    rstn_i      = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    applyStimulus(4'hF, 4'h0, 4'h0);
    for (int k = 0; k < NUM_REQ; k++) setReq(k, ADDR_W'(k + 1), '0);
    nextCycle();
    settle();
    checkOutput("rst_ready", 32'(req_ready_o), 32'h0);
    checkOutput("rst_rd_en", 32'(mem_rd_en_o), 32'h0);
    checkOutput("rst_wr_en", 32'(mem_wr_en_o), 32'h0);
    checkOutput("rst_addr", 32'(mem_addr_o), 32'h0);
    checkOutput("rst_wdata", 32'(mem_wr_data_o), 32'h0);
    nextCycle();
    settle();
    checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    checkOutput("rst_rsp_rdata", 32'(rsp_rdata_o), 32'h0);

    // Four continuous readers rotate 0,1,2,3 with one-cycle responses.
    nextCycle();
    rstn_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      checkOutput($sformatf("rr_ready_%0d", i), 32'(req_ready_o), 32'(1 << (i % 4)));
      checkOutput($sformatf("rr_addr_%0d", i), 32'(mem_addr_o), 32'((i % 4) + 1));
      checkOutput($sformatf("rr_rd_en_%0d", i), 32'(mem_rd_en_o), 32'h1);
      if (i == 0) begin
        checkOutput("rr_rsp_valid_0", 32'(rsp_valid_o), 32'h0);
      end else begin
        p = (i - 1) % 4;
        checkOutput($sformatf("rr_rsp_valid_%0d", i), 32'(rsp_valid_o), 32'(1 << p));
        checkOutput($sformatf("rr_rsp_rdata_%0d", i), 32'(rsp_rdata_o), 32'(16'h1111 * (p + 1)));
      end
      nextCycle();
    end

    // Write BEEF to addr 7 by requester 2, read it back by requester 0.
    setReq(2, 5'd7, 16'hBEEF);
    applyStimulus(4'b0100, 4'b0100, 4'b0000);
    settle();
    checkOutput("wr_ready", 32'(req_ready_o), 32'h4);
    checkOutput("wr_en", 32'(mem_wr_en_o), 32'h1);
    checkOutput("wr_rd_en", 32'(mem_rd_en_o), 32'h0);
    checkOutput("wr_addr", 32'(mem_addr_o), 32'd7);
    checkOutput("wr_data", 32'(mem_wr_data_o), 32'hBEEF);
    checkOutput("wr_last_rsp_valid", 32'(rsp_valid_o), 32'h8);
    checkOutput("wr_last_rsp_rdata", 32'(rsp_rdata_o), 32'h4444);
    nextCycle();
    setReq(0, 5'd7, 16'h0);
    applyStimulus(4'b0001, 4'b0000, 4'b0000);
    settle();
    checkOutput("rd7_ready", 32'(req_ready_o), 32'h1);
    checkOutput("rd7_no_wr_rsp", 32'(rsp_valid_o), 32'h0);
    nextCycle();
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    settle();
    checkOutput("rd7_rsp_valid", 32'(rsp_valid_o), 32'h1);
    checkOutput("rd7_rsp_rdata", 32'(rsp_rdata_o), 32'hBEEF);
    nextCycle();

    // Requester 1 bursts 4 beats, then pointer 2 picks 3, then pointer 0 picks 0.
    applyStimulus(4'b1011, 4'b0000, 4'b0010);
    for (int i = 0; i < 6; i++) begin
      settle();
      checkOutput($sformatf("lock_ready_%0d", i), 32'(req_ready_o),
                  (i < 4) ? 32'h2 : ((i == 4) ? 32'h8 : 32'h1));
      nextCycle();
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    nextCycle();

    // Owner drops valid in its second beat: nobody granted, then requester 3.
    applyStimulus(4'b1010, 4'b0000, 4'b0010);
    settle();
    checkOutput("drop_first", 32'(req_ready_o), 32'h2);
    nextCycle();
    applyStimulus(4'b1000, 4'b0000, 4'b0000);
    settle();
    checkOutput("drop_stall", 32'(req_ready_o), 32'h0);
    checkOutput("drop_stall_rd_en", 32'(mem_rd_en_o), 32'h0);
    nextCycle();
    settle();
    checkOutput("drop_next", 32'(req_ready_o), 32'h8);
    nextCycle();

    // Reset right after a read grant drops the response and the pointer.
    setReq(0, 5'd1, 16'h0);
    applyStimulus(4'b0001, 4'b0000, 4'b0001);
    settle();
    checkOutput("mrst_grant", 32'(req_ready_o), 32'h1);
    nextCycle();
    rstn_i = 1'b0;
    settle();
    checkOutput("mrst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    checkOutput("mrst_rsp_rdata", 32'(rsp_rdata_o), 32'h0);
    checkOutput("mrst_ready", 32'(req_ready_o), 32'h0);
    checkOutput("mrst_rd_en", 32'(mem_rd_en_o), 32'h0);
    nextCycle();
    rstn_i = 1'b1;
    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    settle();
    checkOutput("mrst_restart", 32'(req_ready_o), 32'h1);
    checkOutput("mrst_no_rsp", 32'(rsp_valid_o), 32'h0);
    nextCycle();

    // Ten idle cycles leave the pointer at 1.
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      settle();
      checkOutput($sformatf("idle_ready_%0d", i), 32'(req_ready_o), 32'h0);
      checkOutput($sformatf("idle_en_%0d", i), 32'({mem_rd_en_o, mem_wr_en_o}), 32'h0);
      checkOutput($sformatf("idle_addr_%0d", i), 32'(mem_addr_o), 32'h0);
      nextCycle();
    end
    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    settle();
    checkOutput("idle_ptr_kept", 32'(req_ready_o), 32'h2);
    nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
